// File: rtl/instr_bus_mux.sv
// Instruction-side interconnect: one Ibex fetch host, boot ROM (slave 0) and SRAM (slave 1).
// In-order ID FIFO steers each response back from the slave that owns the oldest request.
module instr_bus_mux #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_FF00,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  output logic        s0_req_o,
  input  logic        s0_gnt_i,
  output logic [31:0] s0_addr_o,
  input  logic        s0_rvalid_i,
  input  logic [31:0] s0_rdata_i,
  input  logic [6:0]  s0_rdata_intg_i,
  input  logic        s0_err_i,
  output logic        s1_req_o,
  input  logic        s1_gnt_i,
  output logic [31:0] s1_addr_o,
  input  logic        s1_rvalid_i,
  input  logic [31:0] s1_rdata_i,
  input  logic [6:0]  s1_rdata_intg_i,
  input  logic        s1_err_i,
  output logic        proto_err_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    SEL_S0     = 2'd0,
    SEL_S1     = 2'd1,
    SEL_DECERR = 2'd2
  } sel_e;

  sel_e          sel;
  sel_e          head;
  sel_e          fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          proto_err_q, proto_err_d;
  logic          full, empty, push, pop;
  logic          stray0, stray1;

  // Slave 0 wins when both windows overlap.
  always_comb begin
    sel = SEL_DECERR;
    if ((instr_addr_i & S0_MASK) == S0_BASE) begin
      sel = SEL_S0;
    end else if ((instr_addr_i & S1_MASK) == S1_BASE) begin
      sel = SEL_S1;
    end
  end

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rptr_q];

  assign s0_addr_o = instr_addr_i;
  assign s1_addr_o = instr_addr_i;
  assign s0_req_o  = instr_req_i & (sel == SEL_S0) & ~full;
  assign s1_req_o  = instr_req_i & (sel == SEL_S1) & ~full;

  always_comb begin
    instr_gnt_o = 1'b0;
    if (instr_req_i && !full) begin
      case (sel)
        SEL_S0:  instr_gnt_o = s0_gnt_i;
        SEL_S1:  instr_gnt_o = s1_gnt_i;
        default: instr_gnt_o = 1'b1;
      endcase
    end
  end

  assign push = instr_gnt_o;

  always_comb begin
    instr_rvalid_o     = 1'b0;
    instr_rdata_o      = '0;
    instr_rdata_intg_o = '0;
    instr_err_o        = 1'b0;
    pop                = 1'b0;
    if (!empty) begin
      case (head)
        SEL_S0: begin
          instr_rvalid_o     = s0_rvalid_i;
          instr_rdata_o      = s0_rdata_i;
          instr_rdata_intg_o = s0_rdata_intg_i;
          instr_err_o        = s0_err_i;
          pop                = s0_rvalid_i;
        end
        SEL_S1: begin
          instr_rvalid_o     = s1_rvalid_i;
          instr_rdata_o      = s1_rdata_i;
          instr_rdata_intg_o = s1_rdata_intg_i;
          instr_err_o        = s1_err_i;
          pop                = s1_rvalid_i;
        end
        default: begin
          instr_rvalid_o = 1'b1;
          instr_err_o    = 1'b1;
          pop            = 1'b1;
        end
      endcase
    end
  end

  // A response from a slave that does not own the head entry is dropped and flagged.
  assign stray0      = s0_rvalid_i & (empty | (head != SEL_S0));
  assign stray1      = s1_rvalid_i & (empty | (head != SEL_S1));
  assign proto_err_d = proto_err_q | stray0 | stray1;
  assign proto_err_o = proto_err_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_instr_bus_mux.sv
// Randomized scoreboard bench for instr_bus_mux: stimulus pushes expected responses,
// an independent monitor pops them whenever the host sees rvalid.
module tb_instr_bus_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        s0_req_o, s0_gnt_i, s0_rvalid_i, s0_err_i;
  logic [31:0] s0_addr_o, s0_rdata_i;
  logic [6:0]  s0_rdata_intg_i;
  logic        s1_req_o, s1_gnt_i, s1_rvalid_i, s1_err_i;
  logic [31:0] s1_addr_o, s1_rdata_i;
  logic [6:0]  s1_rdata_intg_i;
  logic        proto_err_o;

  instr_bus_mux dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
    .s0_req_o(s0_req_o), .s0_gnt_i(s0_gnt_i), .s0_addr_o(s0_addr_o),
    .s0_rvalid_i(s0_rvalid_i), .s0_rdata_i(s0_rdata_i),
    .s0_rdata_intg_i(s0_rdata_intg_i), .s0_err_i(s0_err_i),
    .s1_req_o(s1_req_o), .s1_gnt_i(s1_gnt_i), .s1_addr_o(s1_addr_o),
    .s1_rvalid_i(s1_rvalid_i), .s1_rdata_i(s1_rdata_i),
    .s1_rdata_intg_i(s1_rdata_intg_i), .s1_err_i(s1_err_i),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    longint      cyc;
    logic [31:0] rdata;
    logic [6:0]  intg;
    logic        err;
  } entry_t;

  entry_t outQ[$];
  entry_t expQ[$];
  entry_t monEntry;
  int     vectors = 0;
  int     miscompares = 0;
  longint cycle = 0;
  bit     expProto = 0;
  bit     randErr = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Address map from the rule: ROM = 0x0000_00xx, SRAM = 0x0001_xxxx, else error.
  function automatic int decode(input logic [31:0] a);
    if (a < 32'h0000_0100) return 0;
    if (a >= 32'h0001_0000 && a < 32'h0002_0000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0: return ($urandom % 256) & 32'hFC;
      1: return 32'h0001_0000 + (($urandom % 65536) & 32'hFFFC);
      2: return 32'h8000_0000;
      3: return 32'h0000_0100;
      4: return 32'h0001_FFFC;
      default: return $urandom;
    endcase
  endfunction

  // Responses pop off the scoreboard in host-arrival order.
  always @(negedge clk) begin
    if (instr_rvalid_o) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid=1, required rvalid=0");
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("response", {24'h0, instr_err_o, instr_rdata_intg_o, instr_rdata_o},
                    {24'h0, monEntry.err, monEntry.intg, monEntry.rdata});
      end
    end
  end

  task automatic applyStimulus(input bit req, input logic [31:0] addr, input bit g0, input bit g1,
                               input bit resp, input logic [31:0] rdata);
    entry_t e;
    entry_t h;
    bit     consume;
    bit     expGnt;
    int     sel;
    int     startSize;
    @(posedge clk);
    #1;
    instr_req_i = req;
    instr_addr_i = addr;
    s0_gnt_i = g0;
    s1_gnt_i = g1;
    s0_rvalid_i = 1'b0;
    s1_rvalid_i = 1'b0;
    s0_rdata_i = $urandom;
    s1_rdata_i = $urandom;
    s0_rdata_intg_i = 7'($urandom);
    s1_rdata_intg_i = 7'($urandom);
    s0_err_i = 1'($urandom);
    s1_err_i = 1'($urandom);
    consume = 0;
    if (outQ.size() > 0 && outQ[0].cyc < cycle) begin
      h = outQ[0];
      if (h.kind == 2) begin
        consume = 1;
      end else if (resp) begin
        consume = 1;
        if (h.kind == 0) begin
          s0_rvalid_i = 1'b1; s0_rdata_i = h.rdata; s0_rdata_intg_i = h.intg; s0_err_i = h.err;
        end else begin
          s1_rvalid_i = 1'b1; s1_rdata_i = h.rdata; s1_rdata_intg_i = h.intg; s1_err_i = h.err;
        end
      end
    end
    sel = decode(addr);
    startSize = outQ.size();
    expGnt = req && startSize < 2 && (sel == 0 ? g0 : (sel == 1 ? g1 : 1'b1));
    @(negedge clk);
    checkOutput("gnt_s0req_s1req", {61'h0, instr_gnt_o, s0_req_o, s1_req_o},
                {61'h0, expGnt, req && sel == 0 && startSize < 2, req && sel == 1 && startSize < 2});
    checkOutput("slave_addr", {s0_addr_o, s1_addr_o}, {addr, addr});
    checkOutput("proto_err", {63'h0, proto_err_o}, {63'h0, expProto});
    if (startSize == 0)
      checkOutput("idle_response", {24'h0, instr_rvalid_o, instr_err_o, instr_rdata_intg_o, instr_rdata_o}, 64'h0);
    if (consume) void'(outQ.pop_front());
    if (expGnt) begin
      e.kind = sel;
      e.cyc = cycle;
      if (sel == 2) begin
        e.rdata = '0; e.intg = '0; e.err = 1'b1;
      end else begin
        e.rdata = rdata; e.intg = 7'($urandom); e.err = randErr && ($urandom_range(0, 4) == 0);
      end
      outQ.push_back(e);
      expQ.push_back(e);
    end
  endtask

  task automatic drainAll();
    for (int n = 0; n < 50 && outQ.size() > 0; n++) applyStimulus(0, 32'h0, 0, 0, 1, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0);
    checkOutput("missing_response", 64'(expQ.size()), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    instr_req_i = 0; instr_addr_i = 0;
    s0_gnt_i = 0; s0_rvalid_i = 0; s0_rdata_i = 0; s0_rdata_intg_i = 0; s0_err_i = 0;
    s1_gnt_i = 0; s1_rvalid_i = 0; s1_rdata_i = 0; s1_rdata_intg_i = 0; s1_err_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                {21'h0, instr_rvalid_o, instr_err_o, instr_rdata_intg_o, instr_rdata_o,
                 proto_err_o, s0_req_o, s1_req_o, instr_gnt_o},
                64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single ROM fetch");
    applyStimulus(1, 32'h0000_0080, 1, 0, 0, 32'h0000_0513);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0);
    drainAll();

    $display("[TB] unmapped fetch");
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 32'h0);
    drainAll();

    $display("[TB] back-to-back mixed, full with simultaneous pop");
    applyStimulus(1, 32'h0000_0084, 1, 0, 0, 32'h1111_0084);
    applyStimulus(1, 32'h0001_0000, 0, 1, 0, 32'h2222_0000);
    applyStimulus(1, 32'h0000_0088, 1, 1, 0, 32'h0);
    applyStimulus(1, 32'h0000_0088, 1, 1, 1, 32'h0);
    applyStimulus(1, 32'h0000_0088, 1, 1, 1, 32'h3333_0088);
    drainAll();

    $display("[TB] randomized traffic");
    randErr = 1;
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) < 7, randAddr(), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom);
    randErr = 0;
    drainAll();

    $display("[TB] stray slave response");
    @(posedge clk);
    #1;
    instr_req_i = 0;
    s1_rvalid_i = 1'b1;
    s1_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("stray_rvalid", {63'h0, instr_rvalid_o}, 64'h0);
    @(posedge clk);
    #1;
    s1_rvalid_i = 1'b0;
    expProto = 1;
    @(negedge clk);
    checkOutput("proto_err_set", {63'h0, proto_err_o}, 64'h1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 32'h0000_0040, 1, 0, 0, 32'h4444_0040);
    @(posedge clk);
    #1;
    rst = 1'b1;
    instr_req_i = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    outQ.delete();
    expQ.delete();
    expProto = 0;
    @(negedge clk);
    checkOutput("post_reset", {62'h0, instr_rvalid_o, proto_err_o}, 64'h0);
    applyStimulus(1, 32'h0000_0000, 1, 0, 0, 32'h0000_0093);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0);
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
